// File: rtl/processor_pkg.sv
// processor_pkg
// Shared definitions for the datapath muxing slice.
//   WORD_WIDTH     default datapath word width
//   MODE_SELECT    mode encoding for explicit op-driven selection
//   MODE_RR        mode encoding for round-robin arbitration
//   outState_t     output register occupancy (EMPTY / FULL)
//   nextIndex()    increments a channel index, wrapping modulo the channel count
package processor_pkg;

   localparam int WORD_WIDTH = 16;

   localparam logic MODE_SELECT = 1'b0;
   localparam logic MODE_RR     = 1'b1;

   typedef enum logic {
      StEmpty = 1'b0,
      StFull  = 1'b1
   } outState_t;

   // Channel after idx, so the last channel wraps back to channel 0.
   function automatic int nextIndex(input int idx, input int n);
      return (idx + 1) % n;
   endfunction

endpackage

// File: rtl/mux_arbiter_component_if.sv
// mux_arbiter_component_if
// Bundles the multi-channel producer side and the single consumer side of
// the arbitrating mux.
//   in_data    packed channel words, channel i at [i*WIDTH +: WIDTH]
//   in_valid   per-channel request
//   in_ready   per-channel accept, one-hot or zero
//   op         explicit channel select
//   mode       0 = select, 1 = round-robin
//   out_data   registered output word
//   out_src    channel index that supplied out_data
//   out_valid  output register holds a word
//   out_ready  consumer accepts the word
// Modports: slave = the mux itself, master = the surrounding producers/consumer.
import processor_pkg::*;

interface mux_arbiter_component_if #(
   parameter int WIDTH  = WORD_WIDTH,
   parameter int NUM_IN = 4,
   parameter int SEL_W  = $clog2(NUM_IN)
);

   logic [NUM_IN*WIDTH-1:0] in_data;
   logic [NUM_IN-1:0]       in_valid;
   logic [NUM_IN-1:0]       in_ready;
   logic [SEL_W-1:0]        op;
   logic                    mode;
   logic [WIDTH-1:0]        out_data;
   logic [SEL_W-1:0]        out_src;
   logic                    out_valid;
   logic                    out_ready;

   modport slave (
      input  in_data, in_valid, op, mode, out_ready,
      output in_ready, out_data, out_src, out_valid
   );

   modport master (
      output in_data, in_valid, op, mode, out_ready,
      input  in_ready, out_data, out_src, out_valid
   );

endinterface

// File: rtl/mux_arbiter_component_rr_arbiter.sv
// rr_arbiter
// Purely combinational round-robin picker. The pointer register lives in
// the parent; this block only scans.
//   req         request vector, one bit per channel
//   ptr         channel with highest priority this cycle
//   grant       index of the first requester at or after ptr (wrapping)
//   grantValid  at least one channel is requesting
import processor_pkg::*;

module rr_arbiter #(
   parameter int NUM_IN = 4,
   parameter int SEL_W  = $clog2(NUM_IN)
) (
   input  logic [NUM_IN-1:0] req,
   input  logic [SEL_W-1:0]  ptr,
   output logic [SEL_W-1:0]  grant,
   output logic              grantValid
);

   int scanIdx;

   // Walk the offsets from farthest to nearest so that the requester
   // closest to ptr is the last one written and therefore wins.
   always_comb begin
      grant      = '0;
      grantValid = 1'b0;
      scanIdx    = 0;
      for (int k = NUM_IN - 1; k >= 0; k--) begin
         scanIdx = (int'(ptr) + k) % NUM_IN;
         if (req[SEL_W'(scanIdx)]) begin
            grant      = SEL_W'(scanIdx);
            grantValid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux_arbiter_component.sv
// mux_arbiter_component
// Selects one of NUM_IN word-wide sources into a single registered output
// stage with valid/ready handshaking, either by explicit op select or by
// round-robin arbitration among requesting channels.
//   clk     rising-edge clock
//   reset   synchronous, active-high reset
//   bus     mux_arbiter_component_if.slave (channel inputs, op/mode,
//           registered output word, source index and handshakes)
// Build option: define MUX_ARB_ROUND_ROBIN_EN to build round-robin mode and
// its pointer register. Without it, mode is ignored and op always selects.
import processor_pkg::*;

module mux_arbiter_component #(
   parameter int WIDTH  = WORD_WIDTH,
   parameter int NUM_IN = 4,
   parameter int SEL_W  = $clog2(NUM_IN)
) (
   input logic                   clk,
   input logic                   reset,
   mux_arbiter_component_if.slave bus
);

   outState_t        state;
   logic [WIDTH-1:0] dataReg;
   logic [SEL_W-1:0] srcReg;
   logic             canLoad;
   logic             selValid;
   logic             grantValid;
   logic [SEL_W-1:0] grantIdx;
   logic             transfer;
   logic [WIDTH-1:0] selData;

   // The output register can take a new word when it is empty, or when the
   // consumer drains it in this same cycle.
   assign canLoad  = (state == StEmpty) || bus.out_ready;
   assign selValid = (int'(bus.op) < NUM_IN) && bus.in_valid[bus.op];
   assign transfer = !reset && canLoad && grantValid;

`ifdef MUX_ARB_ROUND_ROBIN_EN
   logic [SEL_W-1:0] rrPtr;
   logic [SEL_W-1:0] rrGrant;
   logic             rrGrantValid;

   rr_arbiter #(
      .NUM_IN (NUM_IN),
      .SEL_W  (SEL_W)
   ) u_rr_arbiter (
      .req        (bus.in_valid),
      .ptr        (rrPtr),
      .grant      (rrGrant),
      .grantValid (rrGrantValid)
   );

   // Mode picks whose grant is used; a held word is unaffected because
   // the grant only matters when the register can load.
   always_comb begin
      grantIdx   = bus.op;
      grantValid = selValid;
      if (bus.mode == MODE_RR) begin
         grantIdx   = rrGrant;
         grantValid = rrGrantValid;
      end
   end

   // The pointer moves past the winner only on round-robin transfers, so
   // select-mode traffic does not disturb the fairness rotation.
   always_ff @(posedge clk) begin
      if (reset) begin
         rrPtr <= '0;
      end else if (transfer && bus.mode == MODE_RR) begin
         rrPtr <= SEL_W'(nextIndex(int'(grantIdx), NUM_IN));
      end
   end
`else
   logic unusedMode;

   // Without round-robin support the explicit select is the only source of
   // grants and mode is deliberately left unconnected.
   always_comb begin
      grantIdx   = bus.op;
      grantValid = selValid;
   end

   assign unusedMode = bus.mode;
`endif

   // Only the granted channel sees ready, and only when the register can
   // actually take its word; reset forces every ready low.
   always_comb begin
      bus.in_ready = '0;
      if (transfer) begin
         bus.in_ready[grantIdx] = 1'b1;
      end
   end

   // Pull the granted channel's word out of the packed input bus.
   always_comb begin
      selData = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         if (grantIdx == SEL_W'(i)) begin
            selData = bus.in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   // Two-state output register: a transfer always fills it (even while
   // draining), a drain with nothing behind it empties it, and data/source
   // hold their last values once the word has gone.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= StEmpty;
         dataReg <= '0;
         srcReg  <= '0;
      end else if (transfer) begin
         state   <= StFull;
         dataReg <= selData;
         srcReg  <= grantIdx;
      end else if (bus.out_ready) begin
         state   <= StEmpty;
      end
   end

   assign bus.out_valid = (state == StFull);
   assign bus.out_data  = dataReg;
   assign bus.out_src   = srcReg;

endmodule

// File: doc/mux_arbiter_component.md
# mux_arbiter_component

Parametrised successor to the fixed 4-way 16-bit mux. Selects one of `NUM_IN` word-wide sources into a single registered output stage with valid/ready handshaking. Sources are chosen either by an explicit select (`op`, as before) or by round-robin arbitration among requesting inputs. Sits between datapath producers (ALU, memory read, immediate, PC) and shared consumers such as the register-file write port.

## Interface
Parameters:
- `WIDTH`, 16, data word width in bits
- `NUM_IN`, 4, number of input channels (≥2)
- `SEL_W`, `$clog2(NUM_IN)`, select and source-index width (derived; do not override)

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `in_data`  in  `NUM_IN*WIDTH`  packed inputs; channel i at bits `[i*WIDTH +: WIDTH]`
- `in_valid`  in  `NUM_IN`  per-channel request
- `in_ready`  out  `NUM_IN`  per-channel accept; one-hot or zero
- `op`  in  `SEL_W`  explicit channel select (select mode)
- `mode`  in  1  0 = select mode, 1 = round-robin mode
- `out_data`  out  `WIDTH`  registered output word
- `out_src`  out  `SEL_W`  index of the channel that supplied `out_data`
- `out_valid`  out  1  output register holds a word
- `out_ready`  in  1  consumer accepts the word

## Operation
- Single output register, two states: EMPTY (`out_valid`=0) and FULL (`out_valid`=1).
- `can_load` = EMPTY, or FULL with `out_ready`=1 (drain and refill in the same cycle).
- Select mode: `grant` = `op` if `in_valid[op]`=1 and `op` < `NUM_IN`; otherwise no grant.
- Round-robin mode: `grant` = first i with `in_valid[i]`=1, scanning from `rr_ptr` upward and wrapping modulo `NUM_IN`. If no input is valid, there is no grant.
- `in_ready[i]` = `can_load` && grant exists && grant == i. It is combinational and may depend on `out_ready`.
- Transfer on channel i when `in_valid[i]` && `in_ready[i]`:
  - next edge loads `out_data` ← channel i data and `out_src` ← i
  - `out_valid` ← 1
- FULL with `out_ready`=1 and no transfer: `out_valid` ← 0. `out_data` and `out_src` hold their last values.
- FULL with `out_ready`=0: all outputs hold and all `in_ready` are 0.
- `rr_ptr` update: on a round-robin transfer, `rr_ptr` ← (grant+1) mod `NUM_IN`, so `NUM_IN-1` wraps to 0. `rr_ptr` is unchanged on select-mode transfers and on idle cycles.
- `mode` or `op` changes while FULL do not affect the held word. They apply to the next grant only.

## Timing
- Reset values:
  - `out_valid`=0, `out_data`=0, `out_src`=0, `rr_ptr`=0
  - `in_ready`=0 while `reset`=1
- Reset asserted mid-operation drops any held word; no partial state survives.
- Latency: input accepted at edge N appears on `out_data` with `out_valid`=1 after edge N.
- Throughput: one word per cycle when `out_ready` is held at 1.
- Fairness: under continuous requests from all channels in round-robin mode, each channel is granted once every `NUM_IN` transfers.

## Configuration
- `MUX_ARB_ROUND_ROBIN_EN` defined: round-robin mode and the `rr_ptr` register are built; `mode` behaves as specified.
- Not defined: no `rr_ptr` is built, `mode` is ignored, and the block always operates in select mode. All ports remain present.

## Structure
- The shared package `processor_pkg` holds:
  - `WORD_WIDTH` = 16 (default source for `WIDTH`)
  - mode encodings `MODE_SELECT` = 1'b0 and `MODE_RR` = 1'b1
- Sub-module `rr_arbiter`, parametrised by `NUM_IN`:
  - inputs: request vector, pointer
  - outputs: grant index, grant-valid
  - purely combinational; the pointer register lives in the parent.

## Test plan
- Reset held 10 cycles with all `in_valid`=1 → `out_valid`=0, `out_data`=0, `in_ready`=0 throughout; first transfer happens on the first edge after release.
- Select mode, `WIDTH`=16, `NUM_IN`=4, inputs 0/1/2/3, `out_ready`=1, `op` stepping 00→01→10→11 → `out_data` = 0,1,2,3 one cycle after each step, with `out_src` matching `op`.
- Round-robin mode, all four channels valid continuously, `out_ready`=1 → `out_src` sequence 0,1,2,3,0,1 (pointer wraps at 3).
- Round-robin mode with only channels 1 and 3 valid, starting `rr_ptr`=2 → grants 3,1,3,1.
- Backpressure: FULL with `out_ready`=0 for 5 cycles → `out_data` is stable and `in_ready`=0. Raising `out_ready` produces drain and refill in the same cycle with no bubble.
- Select mode with `op`=2 and `in_valid`=4'b1011 → no grant and `out_valid` stays 0. Asserting `in_valid[2]` produces a transfer on the next edge.
